// File: rtl/booth_mult_seq.sv
// Sequential signed radix-4 Booth multiplier.
// One Booth digit per clock: WIDTH/2 iterations after the start-capture edge,
// then a single-cycle ready pulse with the registered product and overflow flag.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow,
  output logic               ready,
  output logic               busy
);

  // Adder is two bits wider than the operands so that +-2M never wraps,
  // including the -2^(WIDTH-1) * -2^(WIDTH-1) corner.
  localparam int AW = WIDTH + 2;
  // Full shift pair: accumulator, multiplier, and the implicit bit below the LSB.
  localparam int PW = AW + WIDTH + 1;
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [AW-1:0]      mcand_q;
  logic [AW-1:0]      acc_q;
  logic [WIDTH:0]     mplier_q;   // {remaining multiplier bits, previous bit}
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] product_q;
  logic               overflow_q;
  logic               ready_q;
  logic               busy_q;

  logic [AW-1:0]      mcand2;
  logic [AW-1:0]      addend_d;
  logic [AW-1:0]      sum_d;
  logic [PW-1:0]      shifted_d;
  logic [2*WIDTH-1:0] product_d;
  logic               overflow_d;

  assign mcand2 = {mcand_q[AW-2:0], 1'b0};

  // One Booth step: pick 0/+-M/+-2M from the current triplet, add, shift by 2.
  always_comb begin
    addend_d = '0;
    case (mplier_q[2:0])
      3'b001, 3'b010: addend_d = mcand_q;
      3'b011:         addend_d = mcand2;
      3'b100:         addend_d = -mcand2;
      3'b101, 3'b110: addend_d = -mcand_q;
      default:        addend_d = '0;
    endcase
    sum_d      = acc_q + addend_d;
    shifted_d  = $signed({sum_d, mplier_q}) >>> 2;
    // After the last shift the low product half sits above the implicit bit.
    product_d  = shifted_d[2*WIDTH:1];
    overflow_d = !((&product_d[2*WIDTH-1:WIDTH-1]) || !(|product_d[2*WIDTH-1:WIDTH-1]));
  end

  // Control FSM with registered outputs; product is held until the next result lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (start) begin
            mcand_q  <= {{2{op_a[WIDTH-1]}}, op_a};
            acc_q    <= '0;
            mplier_q <= {op_b, 1'b0};
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q    <= shifted_d[PW-1:WIDTH+1];
          mplier_q <= shifted_d[WIDTH:0];
          if (count_q == LAST) begin
            product_q  <= product_d;
            overflow_q <= overflow_d;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            count_q    <= count_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign product  = product_q;
  assign overflow = overflow_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed corners plus random signed pairs,
// checked against plain 64-bit signed multiplication.
module tb_booth_mult_seq;

  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [2*W-1:0] product;
  logic           overflow;
  logic           ready;
  logic           busy;

  int n_chk  = 0;
  int n_pass = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .product  (product),
    .overflow (overflow),
    .ready    (ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic longint ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic ref_ovf(input longint p);
    return p != longint'(int'(p));
  endfunction

  // Present a request; caller is at a falling edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
  endtask

  // Wait for the result of the launched op, scrambling operands during the run
  // and optionally pulsing start at cycle 'glitch' (0 = never).
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input string tag, input int glitch);
    longint exp;
    int     cyc;
    bit     busy_ok;
    exp = ref_prod(a, b);
    @(negedge clk);
    start   = 1'b0;
    cyc     = 0;
    busy_ok = 1'b1;
    while (!ready && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
      if (glitch != 0 && cyc == glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'd16);
    chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    chk({tag, " product"}, product, exp);
    chk({tag, " overflow"}, 64'(overflow), 64'(ref_ovf(exp)));
    @(negedge clk);
    chk({tag, " ready_pulse"}, 64'(ready), 64'd0);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    launch(a, b);
    finish_op(a, b, tag, 0);
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst product", product, 64'd0);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    do_op(32'd7, 32'hFFFF_FFFD, "t1");
    chk("t1 const", product, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(32'h8000_0000, 32'h8000_0000, "t2a");
    chk("t2a const", product, 64'h4000_0000_0000_0000);
    chk("t2a ovf", 64'(overflow), 64'd1);
    do_op(32'h7FFF_FFFF, 32'd2, "t2b");
    chk("t2b const", product, 64'h0000_0000_FFFF_FFFE);
    do_op(32'd0, 32'hDEAD_BEEF, "t3");
    do_op(32'hFFFF_FFFF, 32'h8000_0000, "t3b");

    // Start pulsed mid-run must be ignored
    launch(32'd1234, 32'hFFFF_F000);
    finish_op(32'd1234, 32'hFFFF_F000, "t4", 5);
    chk("t4 idle_after", 64'(busy), 64'd0);

    // Start held high: back-to-back ops
    launch(32'd5, 32'd6);
    @(negedge clk);
    op_a = 32'hFFFF_FFFF;
    op_b = 32'hFFFF_FFFF;
    cyc = 1;
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5a latency", 64'(cyc), 64'd17);
    chk("t5a product", product, 64'd30);
    @(negedge clk);
    cyc = 1;
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5b spacing", 64'(cyc), 64'd17);
    chk("t5b product", product, 64'd1);
    start = 1'b0;
    @(negedge clk);
    chk("t5 ready_pulse", 64'(ready), 64'd0);

    // Async reset in the middle of a run
    launch(32'd3, 32'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6 rst product", product, 64'd0);
    chk("t6 rst busy", 64'(busy), 64'd0);
    chk("t6 rst ready", 64'(ready), 64'd0);
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready) cyc++;
    end
    chk("t6 no_ready", 64'(cyc), 64'd0);
    launch(32'd123, 32'hFFFF_FE38);
    reset = 1'b1;
    finish_op(32'd123, 32'hFFFF_FE38, "t6 after", 0);

    // Random signed pairs, with occasional extreme operands
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: a = $urandom_range(0, 15);
        default: ;
      endcase
      do_op(a, b, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
